// File: rtl/huff_bit_packer.sv
// huff_bit_packer: prefix-code bit packer.
// A code table (char / value / mask per entry) is captured in IDLE by tbl_load. Accepted symbols
// are looked up and their code bits are appended MSB first to a bit buffer. Full OUT_W-bit words
// leave on the out_* stream. After the in_last beat the residue is flushed as a final
// left-aligned, zero-padded word.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   tbl_load                   one-cycle table capture strobe (honoured in IDLE only)
//   tbl_char/value/mask        packed tables; entry i at [(NUM_SYM-1-i)*W +: W]
//   in_valid/ready/last/sym    symbol input stream
//   out_valid/ready/data/last  packed word output stream
//   out_pad                    zero pad bits in the out_last word
//   err_miss                   sticky "symbol not in table" flag
//   busy                       state is not IDLE
module huff_bit_packer #(
    parameter int unsigned NUM_SYM = 5,
    parameter int unsigned CHAR_W  = 7,
    parameter int unsigned CODE_W  = 5,
    parameter int unsigned OUT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tbl_load,
    input  logic [NUM_SYM*CHAR_W-1:0] tbl_char,
    input  logic [NUM_SYM*CODE_W-1:0] tbl_value,
    input  logic [NUM_SYM*CODE_W-1:0] tbl_mask,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [CHAR_W-1:0]         in_sym,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_last,
    output logic [3:0]                out_pad,
    output logic                      err_miss,
    output logic                      busy
);

    localparam int unsigned BUF_W = OUT_W + CODE_W - 1;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] BUF_W_C = CNT_W'(BUF_W);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                    state_q, state_d;
    logic [BUF_W-1:0]          buf_q, buf_d;      // oldest bit at MSB, unused bits kept zero
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_SYM*CHAR_W-1:0] char_q, char_d;
    logic [NUM_SYM*CODE_W-1:0] value_q, value_d;
    logic [NUM_SYM*CODE_W-1:0] mask_q, mask_d;
    logic                      err_q, err_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;
    logic [3:0]                out_pad_q, out_pad_d;

    logic                      hit;
    logic [CODE_W-1:0]         code;
    logic [CODE_W-1:0]         sel_mask;
    logic [CNT_W-1:0]          len;
    logic                      fire_in, fire_out;

    // Table lookup. Slice i*W holds entry NUM_SYM-1-i, so walking i upward visits entries from
    // the highest index down and the last match written is the lowest-index match.
    always_comb begin
        hit      = 1'b0;
        code     = '0;
        sel_mask = '0;
        len      = '0;
        for (int unsigned i = 0; i < NUM_SYM; i++) begin
            if (mask_q[i*CODE_W +: CODE_W] != '0 && char_q[i*CHAR_W +: CHAR_W] == in_sym) begin
                hit      = 1'b1;
                sel_mask = mask_q[i*CODE_W +: CODE_W];
                code     = value_q[i*CODE_W +: CODE_W] & mask_q[i*CODE_W +: CODE_W];
            end
        end
        for (int unsigned b = 0; b < CODE_W; b++) begin
            len = len + CNT_W'(sel_mask[b]);
        end
    end

    assign in_ready = (state_q == StRun) && (cnt_q < OUT_W_C);
    assign busy     = (state_q != StIdle);
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        char_d      = char_q;
        value_d     = value_q;
        mask_d      = mask_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        out_pad_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (tbl_load) begin
                    char_d  = tbl_char;
                    value_d = tbl_value;
                    mask_d  = tbl_mask;
                    err_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Word removal happens before the append so a same-cycle accept lands correctly.
                if (fire_out) begin
                    buf_d = buf_q << OUT_W;
                    cnt_d = cnt_q - OUT_W_C;
                end
                if (fire_in) begin
                    if (hit) begin
                        buf_d = buf_d | (BUF_W'(code) << (BUF_W_C - cnt_d - len));
                        cnt_d = cnt_d + len;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (fire_out) begin
                    if (out_last_q) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        buf_d = buf_q << OUT_W;
                        cnt_d = cnt_q - OUT_W_C;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Output word registers follow the next buffer state, so they hold steady under stall.
        if (state_d == StRun && cnt_d >= OUT_W_C) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_d[BUF_W-1 -: OUT_W];
        end else if (state_d == StFlush) begin
            // In FLUSH a word is always pending; an empty buffer yields one all-zero last word.
            out_valid_d = 1'b1;
            out_data_d  = buf_d[BUF_W-1 -: OUT_W];
            out_last_d  = (cnt_d <= OUT_W_C);
            if (cnt_d != '0 && cnt_d < OUT_W_C) begin
                out_pad_d = 4'(OUT_W_C - cnt_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            cnt_q       <= '0;
            char_q      <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_pad_q   <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            char_q      <= char_d;
            value_q     <= value_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_pad_q   <= out_pad_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_pad   = out_pad_q;
    assign err_miss  = err_q;

endmodule

// File: tb/tb_huff_bit_packer.sv
// Directed bench for huff_bit_packer: hand-computed packed words for small symbol streams.
module tb_huff_bit_packer;

    logic        clk;
    logic        reset;
    logic        tbl_load;
    logic [34:0] tbl_char;
    logic [24:0] tbl_value;
    logic [24:0] tbl_mask;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  in_sym;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [3:0]  out_pad;
    logic        err_miss;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Handshaken words: {last, pad[3:0], data[7:0]}
    logic [12:0] wq[$];

    localparam logic [34:0] CHARS    = {7'h61, 7'h62, 7'h63, 7'h64, 7'h65};
    localparam logic [24:0] VALUES   = {5'h00, 5'h02, 5'h06, 5'h0E, 5'h0F};
    localparam logic [24:0] MASKS    = {5'h01, 5'h03, 5'h07, 5'h0F, 5'h0F};
    localparam logic [24:0] MASKS_A  = {5'h01, 20'h0};

    huff_bit_packer dut (
        .clk       (clk),
        .reset     (reset),
        .tbl_load  (tbl_load),
        .tbl_char  (tbl_char),
        .tbl_value (tbl_value),
        .tbl_mask  (tbl_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_sym    (in_sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_pad   (out_pad),
        .err_miss  (err_miss),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) wq.push_back({out_last, out_pad, out_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_tbl(input logic [24:0] masks);
        tbl_char  = CHARS;
        tbl_value = VALUES;
        tbl_mask  = masks;
        tbl_load  = 1'b1;
        @(posedge clk); #1;
        tbl_load  = 1'b0;
    endtask

    task automatic send(input logic [6:0] s, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input logic l,
                               input logic [3:0] p);
        int n = 0;
        logic [12:0] w;
        while (wq.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_present"}, 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
            w = wq.pop_front();
            chk({tag, "_data"}, 32'(w[7:0]), 32'(d));
            chk({tag, "_last"}, 32'(w[12]), 32'(l));
            chk({tag, "_pad"}, 32'(w[11:8]), 32'(p));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic stable;
        reset     = 1'b0;
        tbl_load  = 1'b0;
        tbl_char  = '0;
        tbl_value = '0;
        tbl_mask  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_sym    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_pad", 32'(out_pad), 32'd0);
        chk("rst_err_miss", 32'(err_miss), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // a,b,c,d,e(last): 0 10 110 1110 1111 -> 0x5B, 0xBC (pad 2)
        load_tbl(MASKS);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_in_ready", 32'(in_ready), 32'd1);
        send(7'h61, 1'b0);
        send(7'h62, 1'b0);
        send(7'h63, 1'b0);
        send(7'h64, 1'b0);
        send(7'h65, 1'b1);
        expect_word("a_w0", 8'h5B, 1'b0, 4'd0);
        expect_word("a_w1", 8'hBC, 1'b1, 4'd2);
        wait_idle("a");
        chk("a_err", 32'(err_miss), 32'd0);

        // d,e,d,e(last): two full words, no residue
        load_tbl(MASKS);
        send(7'h64, 1'b0);
        send(7'h65, 1'b0);
        send(7'h64, 1'b0);
        send(7'h65, 1'b1);
        expect_word("b_w0", 8'hEF, 1'b0, 4'd0);
        expect_word("b_w1", 8'hEF, 1'b1, 4'd0);
        wait_idle("b");
        repeat (3) @(posedge clk);
        #1;
        chk("b_no_extra", 32'(wq.size()), 32'd0);

        // a, miss, b(last): 010 -> 0x40 pad 5, sticky error
        load_tbl(MASKS);
        send(7'h61, 1'b0);
        send(7'h7A, 1'b0);
        chk("c_err_set", 32'(err_miss), 32'd1);
        send(7'h62, 1'b1);
        expect_word("c_w0", 8'h40, 1'b1, 4'd5);
        wait_idle("c");
        chk("c_err_sticky_idle", 32'(err_miss), 32'd1);
        chk("c_no_extra", 32'(wq.size()), 32'd0);

        // Output stall for 10 cycles with 0x5B pending
        load_tbl(MASKS);
        chk("d_err_cleared", 32'(err_miss), 32'd0);
        out_ready = 1'b0;
        send(7'h61, 1'b0);
        send(7'h62, 1'b0);
        send(7'h63, 1'b0);
        send(7'h64, 1'b0);
        chk("d_stall_valid", 32'(out_valid), 32'd1);
        chk("d_stall_data", 32'(out_data), 32'h5B);
        chk("d_stall_in_ready", 32'(in_ready), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_data !== 8'h5B || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("d_stall_hold", 32'(stable), 32'd1);
        out_ready = 1'b1;
        send(7'h65, 1'b1);
        expect_word("d_w0", 8'h5B, 1'b0, 4'd0);
        expect_word("d_w1", 8'hBC, 1'b1, 4'd2);
        wait_idle("d");

        // Reset mid-stream, then full rerun
        load_tbl(MASKS);
        send(7'h61, 1'b0);
        send(7'h62, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("e_rst_out_valid", 32'(out_valid), 32'd0);
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_err", 32'(err_miss), 32'd0);
        chk("e_rst_in_ready", 32'(in_ready), 32'd0);
        chk("e_rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        load_tbl(MASKS);
        send(7'h61, 1'b0);
        send(7'h62, 1'b0);
        send(7'h63, 1'b0);
        send(7'h64, 1'b0);
        send(7'h65, 1'b1);
        expect_word("e_w0", 8'h5B, 1'b0, 4'd0);
        expect_word("e_w1", 8'hBC, 1'b1, 4'd2);
        wait_idle("e");
        chk("e_no_extra", 32'(wq.size()), 32'd0);

        // Only 'a' in table, a(last) as first beat: one bit -> 0x00 pad 7, DONE then IDLE
        load_tbl(MASKS_A);
        send(7'h61, 1'b1);
        expect_word("f_w0", 8'h00, 1'b1, 4'd7);
        chk("f_done_busy", 32'(busy), 32'd1);
        chk("f_done_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("f_idle_busy", 32'(busy), 32'd0);
        chk("f_no_extra", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/huff_bit_packer.md
HUFF_BIT_PACKER -- requirements
Module: huff_bit_packer

Interface
REQ-001 SHALL have parameter NUM_SYM, default 5: number of code-table entries.
REQ-002 SHALL have parameter CHAR_W, default 7: symbol width in bits.
REQ-003 SHALL have parameter CODE_W, default 5: maximum code length in bits.
REQ-004 SHALL have parameter OUT_W, default 8: packed output word width in bits.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port tbl_load, input, 1 bit: one-cycle strobe that captures the code table.
REQ-008 SHALL have port tbl_char, input, NUM_SYM*CHAR_W bits: entry i occupies bits [(NUM_SYM-1-i)*CHAR_W +: CHAR_W].
REQ-009 SHALL have port tbl_value, input, NUM_SYM*CODE_W bits: code bits for each entry, using the same entry slicing.
REQ-010 SHALL have port tbl_mask, input, NUM_SYM*CODE_W bits: per-entry mask of the form (1<<len)-1; mask 0 marks an unused entry.
REQ-011 SHALL have ports in_valid, in_ready, in_last, and in_sym (input, output, input, input; 1, 1, 1, CHAR_W bits): symbol stream with valid/ready handshake.
REQ-012 SHALL have ports out_valid, out_ready, out_data, and out_last (output, input, output, output; 1, 1, OUT_W, 1 bits): packed word stream.
REQ-013 SHALL have port out_pad, output, 4 bits: number of zero pad bits in the out_last word.
REQ-014 SHALL have port err_miss, output, 1 bit: sticky flag set when a symbol has no table match.
REQ-015 SHALL have port busy, output, 1 bit: asserted whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH, and DONE.
REQ-017 SHALL, in IDLE on tbl_load=1, register all tables, clear err_miss and the bit buffer, and enter RUN; tbl_load SHALL be ignored in any other state.
REQ-018 SHALL hold a bit buffer of at least OUT_W+CODE_W-1 bits with a counter bit_cnt; the oldest bit maps to out_data[OUT_W-1].
REQ-019 SHALL drive in_ready=1 only when state is RUN and bit_cnt<OUT_W.
REQ-020 SHALL, when a symbol is accepted, find the lowest index i with mask_i!=0 and char_i==in_sym, let len=popcount(mask_i), and append value_i[len-1:0] MSB first.
REQ-021 SHALL, on a miss, drop the symbol, set err_miss, and leave the buffer unchanged.
REQ-022 SHALL register out_valid=1 with out_data set to the oldest OUT_W bits whenever bit_cnt>=OUT_W.
REQ-023 SHALL hold out_data, out_last, and out_pad stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid&&out_ready, remove OUT_W bits; a symbol accept in the same cycle SHALL be applied after the removal, with no lost or duplicated bits.
REQ-025 SHALL make a symbol's bits visible on out_data no earlier than the cycle after its acceptance (one-cycle latency minimum).
REQ-026 SHALL, on an accepted beat with in_last=1 (hit or miss), leave RUN for FLUSH.
REQ-027 SHALL, in FLUSH, emit full words first; a remaining 0<bit_cnt<OUT_W SHALL be emitted left-aligned and zero-padded with out_last=1 and out_pad=OUT_W-bit_cnt.
REQ-028 SHALL, in FLUSH, set out_last=1 and out_pad=0 on the final full word when residue is 0.
REQ-029 SHALL, if the buffer is empty on FLUSH entry, emit one word 0x00 with out_last=1 and out_pad=0.
REQ-030 SHALL go FLUSH to DONE after the out_last handshake, and DONE to IDLE on the next cycle.
REQ-031 SHALL keep err_miss unchanged in DONE and IDLE until the next table load.

Reset
REQ-032 SHALL, on reset=0 at a clock edge in any state (including mid-word or mid-flush), go to IDLE and clear buffer, bit_cnt, tables, out_valid, out_last, out_pad, err_miss, in_ready, and busy, so that every output reads 0.
REQ-033 SHALL leave out_data=0 after reset and emit no partial word.

Verification
REQ-034 SHALL cover: table a=0x61 v0 m1, b=0x62 v2 m3, c=0x63 v6 m7, d=0x64 vE mF, e=0x65 vF mF; input a,b,c,d,e(last), out_ready=1 -> 0x5B, then 0xBC with out_last=1, out_pad=2.
REQ-035 SHALL cover: the same table with input d,e,d,e(last) -> 0xEF, then 0xEF with out_last=1, out_pad=0, and no extra word.
REQ-036 SHALL cover: input a,0x7A,b(last) -> err_miss=1, and a single word 0x40 with out_last=1, out_pad=5.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles after 0x5B is presented -> out_data stays 0x5B, in_ready drops once bit_cnt>=8, and the final stream is identical to REQ-034.
REQ-038 SHALL cover: reset=0 after b is accepted in REQ-034 -> next cycle out_valid=0, busy=0, err_miss=0; a reload plus the full rerun then matches REQ-034.
REQ-039 SHALL cover: first beat is a(last) with empty table mask bits apart from a -> one word 0x00 with out_last=1, out_pad=7, then DONE to IDLE.
